// File: rtl/spi_read_buffer.sv
// spi_read_buffer: burst word FIFO between the upstream read stream and the SPI loader, with last tagging and length check
module spi_read_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         word_count,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [DATA_W-1:0]        spi_data,
    output logic                     r_valid,
    output logic                     r_last,
    input  logic                     rb_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     len_err,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] wr_rem_q, wr_rem_d;
    logic len_err_q, len_err_d;
    logic [DATA_W:0] mem_q [DEPTH];
    logic [DATA_W:0] head;
    logic full, empty, wr_en, rd_en, last_wr, accept;
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = wr_ptr_q == rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign last_wr = wr_rem_q == CNT_W'(1);
    assign accept  = (state_q == IDLE) && start;
    assign wr_en   = s_tvalid && s_tready;
    assign rd_en   = r_valid && rb_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (word_count == '0) ? DONE : FILL;
            FILL:  if (wr_en && last_wr) state_d = DRAIN;
            DRAIN: if (rd_en && head[DATA_W]) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end
    always_comb begin
        s_tready = (state_q == FILL) && !full && (wr_rem_q != '0);
        busy     = (state_q == FILL) || (state_q == DRAIN);
        done     = state_q == DONE;
    end
    assign wr_rem_d  = accept ? word_count : wr_en ? wr_rem_q - CNT_W'(1) : wr_rem_q;
    assign len_err_d = accept ? 1'b0 : (wr_en && (s_tlast != last_wr)) ? 1'b1 : len_err_q;
    // The last flag comes from the programmed count; upstream tlast is only used for the length check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_rem_q  <= '0;
            len_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_rem_q  <= wr_rem_d;
            len_err_q <= len_err_d;
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {last_wr, s_tdata};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
    assign r_valid  = !empty;
    assign r_last   = !empty && head[DATA_W];
    assign spi_data = head[DATA_W-1:0];
    assign len_err  = len_err_q;
    assign level    = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_spi_read_buffer.sv
// tb_spi_read_buffer: randomized transfers checked against a queue-based model of the buffer
module tb_spi_read_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 32;
    logic clk = 0, rst = 1, start = 0, s_tvalid = 0, s_tlast = 0, rb_ready = 0;
    logic [CNT_W-1:0] word_count = '0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic s_tready, r_valid, r_last, busy, done, len_err;
    logic [DATA_W-1:0] spi_data;
    logic [$clog2(DEPTH):0] level;
    int n_asrt = 0, n_fail = 0;

    spi_read_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .spi_data(spi_data), .r_valid(r_valid), .r_last(r_last), .rb_ready(rb_ready),
        .busy(busy), .done(done), .len_err(len_err), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_r_valid"}, r_valid, 0);
        chk({tag, "_r_last"}, r_last, 0);
        chk({tag, "_spi_data"}, spi_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_len_err"}, len_err, 0);
        chk({tag, "_level"}, level, 0);
    endtask

    // One transfer: the model holds the expected words in arrival order and the spec's ready rule
    task automatic run_xfer(input int wc, input int tlast_pos, input int base,
                            input int pv, input int pr, input int hold);
        logic [DATA_W:0] q[$];
        int written = 0, readn = 0, cyc = 0;
        logic exp_rdy, wr, rd, exp_err;
        exp_err = 0;
        start = 1;
        word_count = CNT_W'(wc);
        @(posedge clk); #1;
        chk("busy_after_start", busy, wc != 0);
        chk("done_after_start", done, wc == 0);
        while (readn < wc && cyc < 4000) begin
            exp_rdy = written < wc && q.size() < DEPTH;
            start = $urandom_range(15) == 0;
            word_count = CNT_W'($urandom);
            s_tvalid = $urandom_range(99) < pv;
            s_tdata = (base != 0) ? DATA_W'(base + written) : DATA_W'($urandom);
            s_tlast = (written + 1 == tlast_pos);
            rb_ready = cyc >= hold && $urandom_range(99) < pr;
            #1;
            chk("s_tready", s_tready, exp_rdy);
            chk("r_valid", r_valid, q.size() != 0);
            chk("level", level, q.size());
            chk("level_max", level <= DEPTH, 1);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("len_err", len_err, exp_err);
            if (q.size() != 0) begin
                chk("spi_data", spi_data, q[0][DATA_W-1:0]);
                chk("r_last", r_last, q[0][DATA_W]);
            end
            wr = s_tvalid && exp_rdy;
            rd = q.size() != 0 && rb_ready;
            if (rd) begin
                void'(q.pop_front());
                readn++;
            end
            if (wr) begin
                written++;
                q.push_back({written == wc, s_tdata});
                if (s_tlast != (written == wc)) exp_err = 1;
            end
            cyc++;
            @(posedge clk); #1;
        end
        chk("xfer_words_read", readn, wc);
        s_tvalid = 0;
        rb_ready = 0;
        start = 1;
        word_count = CNT_W'(5);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("s_tready_at_done", s_tready, 0);
        chk("len_err_final", len_err, exp_err);
        chk("level_final", level, 0);
        @(posedge clk); #1;
        start = 0;
        chk("done_cleared", done, 0);
        chk("busy_idle", busy, 0);
        chk("len_err_held", len_err, exp_err);
        @(posedge clk); #1;
        chk("start_in_done_ignored", busy, 0);
    endtask

    initial begin
        #12;
        chk_reset_vals("reset");
        rst = 0;
        @(posedge clk); #1;
        run_xfer(4, 4, 'hA0, 100, 100, 0);
        run_xfer(20, 20, 'h100, 100, 100, 25);
        run_xfer(3, 2, 'hB0, 100, 100, 0);
        run_xfer(0, 0, 0, 100, 100, 0);
        run_xfer(64, 64, 0, 60, 60, 0);
        run_xfer(8, 8, 0, 50, 50, 0);
        start = 1;
        word_count = CNT_W'(10);
        @(posedge clk); #1;
        start = 0;
        s_tvalid = 1;
        s_tlast = 0;
        s_tdata = DATA_W'($urandom);
        rb_ready = 0;
        repeat (5) @(posedge clk);
        #1;
        s_tvalid = 0;
        chk("mid_fill_level", level, 5);
        chk("mid_fill_busy", busy, 1);
        #2 rst = 1;
        #1;
        chk_reset_vals("async_reset");
        #3 rst = 0;
        @(posedge clk); #1;
        chk_reset_vals("after_reset");
        run_xfer(2, 2, 'hC0, 100, 100, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
